shreg_fifo: RTL

SRL16E-based first-word-fall-through FIFO that forms the consuming end of the shift-register delay lines in the md5crypt core. Words are shifted into a per-bit SRL16E array and read back from a variable tap, the entry count minus one, into a registered output stage. Consumers get a valid/pop interface instead of a fixed delay. It buffers short bursts between md5core pipeline stages without spending block RAM.

---
 rtl/shreg_fifo_if.sv | 30 +++
 rtl/shreg_fifo.sv | 100 ++++++++++
 2 files changed

// File: rtl/shreg_fifo_if.sv
// Write/read handshake bundle for shreg_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface shreg_fifo_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] din;
   logic             wr_en;
   logic             full;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             rd_en;

   modport master (
      output din,
      output wr_en,
      input  full,
      input  dout,
      input  empty,
      output rd_en
   );

   modport slave (
      input  din,
      input  wr_en,
      output full,
      output dout,
      output empty,
      input  rd_en
   );
endinterface

// File: rtl/shreg_fifo.sv
// SRL16E-style first-word-fall-through FIFO with a registered output stage.
// Optional sticky overflow/underflow flag `err` when SHREG_FIFO_ERR_EN is defined.
module shreg_fifo #(
   parameter int unsigned    WIDTH = 32,
   parameter int unsigned    DEPTH = 16,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic        CLK,
   input  logic        rst_n,
   shreg_fifo_if.slave fifo_io
`ifdef SHREG_FIFO_ERR_EN
   ,
   output logic        err
`endif
);

   localparam int unsigned SrlLen = 16;

   logic [WIDTH-1:0] srl_q [SrlLen];
   logic [4:0]       cnt_q, cnt_d;
   logic [4:0]       cnt_m1;
   logic [3:0]       tap_addr;
   logic [WIDTH-1:0] tap;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             out_valid_q, out_valid_d;
   logic             full;
   logic             wr_acc;
   logic             rd_acc;
   logic             load;

   assign full     = (cnt_q == 5'(DEPTH));
   assign wr_acc   = fifo_io.wr_en & ~full;
   assign rd_acc   = fifo_io.rd_en & out_valid_q;
   assign load     = (~out_valid_q | rd_acc) & (cnt_q != 5'd0);
   assign cnt_m1   = cnt_q - 5'd1;
   assign tap_addr = cnt_m1[3:0];
   assign tap      = srl_q[tap_addr];

   // Shift array carries no reset, like the SRL16E primitive it models.
   always_ff @(posedge CLK) begin
      if (wr_acc) begin
         srl_q[0] <= fifo_io.din;
         for (int i = 1; i < SrlLen; i++) begin
            srl_q[i] <= srl_q[i-1];
         end
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
      unique case ({wr_acc, load})
         2'b10:   cnt_d = cnt_q + 5'd1;
         2'b01:   cnt_d = cnt_q - 5'd1;
         default: cnt_d = cnt_q;
      endcase
      if (load) begin
         dout_d      = tap;
         out_valid_d = 1'b1;
      end else if (rd_acc) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= 5'd0;
         dout_q      <= INIT;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign fifo_io.full  = full;
   assign fifo_io.dout  = dout_q;
   assign fifo_io.empty = ~out_valid_q;

`ifdef SHREG_FIFO_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (fifo_io.wr_en & full) | (fifo_io.rd_en & ~out_valid_q);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule
